restoring_div128: RTL and testbench

//   Multicycle radix-2 restoring divider: 2W-bit dividend / W-bit divisor -> W-bit quotient + W-bit remainder.

---
 rtl/restoring_div128.sv | 117 +++++++++++
 tb/tb_restoring_div128.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/restoring_div128.sv
// Multicycle radix-2 restoring divider: 2W-bit dividend / W-bit divisor -> W-bit quotient and remainder.
// One quotient bit per RUN cycle; divide-by-zero and quotient overflow are resolved at accept time.
module restoring_div128 #(
  parameter int W = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           div_zero,
  output logic           overflow
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_reg;
  logic [W-1:0]   p_reg;
  logic [W-1:0]   q_reg;
  logic [W-1:0]   divisor_reg;
  logic [CW-1:0]  count_reg;

  logic [W:0]     t_val;
  logic [W:0]     diff_val;
  logic           q_bit;
  logic [W-1:0]   p_next;
  logic [W-1:0]   q_next;

  // One restoring step: shift in the next dividend bit, subtract when it fits.
  // P < divisor is maintained, so the W+1-bit difference always fits back into W bits.
  always_comb begin
    t_val    = {p_reg, q_reg[W-1]};
    diff_val = t_val - {1'b0, divisor_reg};
    q_bit    = (t_val >= {1'b0, divisor_reg});
    p_next   = q_bit ? diff_val[W-1:0] : t_val[W-1:0];
    q_next   = {q_reg[W-2:0], q_bit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_zero    <= 1'b0;
      overflow    <= 1'b0;
      count_reg   <= '0;
      p_reg       <= '0;
      q_reg       <= '0;
      divisor_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready) begin
            divisor_reg <= divisor;
            in_ready    <= 1'b0;
            if (divisor == '0) begin
              state_reg <= DONE;
              out_valid <= 1'b1;
              div_zero  <= 1'b1;
              overflow  <= 1'b0;
              quotient  <= '1;
              remainder <= dividend[W-1:0];
            end else if (dividend[2*W-1:W] >= divisor) begin
              // High half not below divisor: the quotient needs more than W bits.
              state_reg <= DONE;
              out_valid <= 1'b1;
              div_zero  <= 1'b0;
              overflow  <= 1'b1;
              quotient  <= '1;
              remainder <= dividend[W-1:0];
            end else begin
              state_reg <= RUN;
              p_reg     <= dividend[2*W-1:W];
              q_reg     <= dividend[W-1:0];
              count_reg <= CW'(W);
            end
          end
        end
        RUN: begin
          p_reg     <= p_next;
          q_reg     <= q_next;
          count_reg <= count_reg - CW'(1);
          if (count_reg == CW'(1)) begin
            state_reg <= DONE;
            out_valid <= 1'b1;
            quotient  <= q_next;
            remainder <= p_next;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_div128.sv
// Directed vector table, hand-written handshake/reset corner sequences and a random
// back-to-back run checked against 128-bit reference arithmetic.
module tb_restoring_div128;

  localparam int W = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           div_zero;
  logic           overflow;

  int checks   = 0;
  int failures = 0;

  restoring_div128 #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [2*W-1:0] dd;
    logic [W-1:0]   dv;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    logic           dz;
    logic           ov;
    int             lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Present one operation at posedge+1; lat counts cycles from the accept edge
  // (accept edge itself = 1) until out_valid is seen high.
  task automatic apply(input logic [2*W-1:0] dd, input logic [W-1:0] dv, input bit noise,
                       output int lat);
    check("accept_ready", {127'd0, in_ready}, 128'd1);
    in_valid = 1'b1;
    dividend = dd;
    divisor  = dv;
    @(posedge clk); #1;
    if (noise) begin
      dividend = {$urandom(), $urandom(), $urandom(), $urandom()};
      divisor  = {$urandom(), $urandom()};
    end else begin
      in_valid = 1'b0;
    end
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 3) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    if (!out_valid) check("result_timeout", {127'd0, out_valid}, 128'd1);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [W-1:0] hq;
    logic [W-1:0] hr;
    bit stable;
    bit seen;

    vecs[0]  = '{128'd2469135780, 64'd20, 64'd123456789, 64'd0, 1'b0, 1'b0, 65};
    vecs[1]  = '{{64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001}, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b0, 65};
    vecs[2]  = '{128'd1000003, 64'd7, 64'd142857, 64'd4, 1'b0, 1'b0, 65};
    vecs[3]  = '{128'd100, 64'd3, 64'd33, 64'd1, 1'b0, 1'b0, 65};
    vecs[4]  = '{128'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1'b1, 1'b0, 1};
    vecs[5]  = '{{64'd1, 64'd0}, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1, 1};
    vecs[6]  = '{{64'd7, 64'd0}, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1, 1};
    vecs[7]  = '{{64'd6, 64'hFFFF_FFFF_FFFF_FFFF}, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd6, 1'b0, 1'b0, 65};
    vecs[8]  = '{{64'd1, 64'd0}, 64'd3, 64'h5555_5555_5555_5555, 64'd1, 1'b0, 1'b0, 65};
    vecs[9]  = '{128'd0, 64'd5, 64'd0, 64'd0, 1'b0, 1'b0, 65};
    vecs[10] = '{{64'd5, 64'd9}, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd9, 1'b1, 1'b0, 1};
    vecs[11] = '{128'd12345, 64'd1, 64'd12345, 64'd0, 1'b0, 1'b0, 65};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_in_ready", {127'd0, in_ready}, 128'd1);
    check("reset_out_valid", {127'd0, out_valid}, 128'd0);
    check("reset_q_r", {quotient, remainder}, 128'd0);
    check("reset_flags", {126'd0, div_zero, overflow}, 128'd0);

    // Directed table; odd entries also wiggle the inputs while the operation runs.
    for (int i = 0; i < 12; i++) begin
      apply(vecs[i].dd, vecs[i].dv, i[0], lat);
      check($sformatf("vec%0d_latency", i), 128'(lat), 128'(vecs[i].lat));
      check($sformatf("vec%0d_quotient", i), {64'd0, quotient}, {64'd0, vecs[i].q});
      check($sformatf("vec%0d_remainder", i), {64'd0, remainder}, {64'd0, vecs[i].r});
      check($sformatf("vec%0d_flags", i), {126'd0, div_zero, overflow}, {126'd0, vecs[i].dz, vecs[i].ov});
      $display("vec%0d dd=%0h dv=%0h q=%0h r=%0h dz=%0b ov=%0b lat=%0d",
               i, vecs[i].dd, vecs[i].dv, quotient, remainder, div_zero, overflow, lat);
      release_result();
      check($sformatf("vec%0d_post_hs", i), {126'd0, out_valid, in_ready}, 128'd1);
    end

    // Back-pressure: hold out_ready low for 10 cycles, then handshake with in_valid high.
    apply(128'd1000003, 64'd7, 1'b0, lat);
    hq = quotient; hr = remainder;
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || quotient !== 64'd142857 || remainder !== 64'd4
          || div_zero || overflow) stable = 1'b0;
    end
    check("hold_stable", {127'd0, stable}, 128'd1);
    in_valid = 1'b1; dividend = 128'd50; divisor = 64'd5;
    release_result();
    check("hs_no_accept_in_ready", {126'd0, out_valid, in_ready}, 128'd1);
    check("hs_q_kept", {hq, hr}, {64'd142857, 64'd4});
    check("hs_q_after", {quotient, remainder}, {64'd142857, 64'd4});
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 80 && !seen; c++) begin
      @(posedge clk); #1;
      seen = out_valid;
    end
    check("late_accept_q_r", {quotient, remainder}, {64'd10, 64'd0});
    $display("hold q=%0d r=%0d then 50/5 q=%0d r=%0d", hq, hr, quotient, remainder);
    release_result();

    // Abort with reset in the middle of RUN; nothing must come out afterwards.
    in_valid = 1'b1; dividend = 128'd1000003; divisor = 64'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (29) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ready_valid", {126'd0, in_ready, out_valid}, 128'd2);
    check("abort_q_r", {quotient, remainder}, 128'd0);
    seen = 1'b0;
    repeat (70) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_emit", {127'd0, seen}, 128'd0);
    apply(128'd100, 64'd3, 1'b0, lat);
    check("abort_then_100_3", {quotient, remainder}, {64'd33, 64'd1});
    $display("abort then 100/3 q=%0d r=%0d lat=%0d", quotient, remainder, lat);
    release_result();

    // Random non-overflow operations against 128-bit reference arithmetic.
    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0]   dv;
      logic [W-1:0]   hi;
      logic [2*W-1:0] dd;
      logic [2*W-1:0] eq;
      logic [2*W-1:0] er;
      bit hs;
      int waits;
      dv = {$urandom(), $urandom()} >> $urandom_range(0, 63);
      if (dv == '0) dv = 64'd1;
      hi = {$urandom(), $urandom()} % dv;
      dd = {hi, $urandom(), $urandom()};
      eq = dd / {64'd0, dv};
      er = dd % {64'd0, dv};
      apply(dd, dv, 1'b0, lat);
      check("rand_q", {64'd0, quotient}, eq);
      check("rand_r", {64'd0, remainder}, er);
      check("rand_inv", {64'd0, quotient} * {64'd0, dv} + {64'd0, remainder}, dd);
      check("rand_flags", {125'd0, div_zero, overflow, lat == 65}, 128'd1);
      $display("rand%0d dd=%0h dv=%0h q=%0h r=%0h", n, dd, dv, quotient, remainder);
      hs = 1'b0;
      waits = 0;
      while (!hs && waits < 50) begin
        out_ready = 1'($urandom_range(0, 1));
        hs = out_ready && out_valid;
        @(posedge clk); #1;
        waits++;
      end
      out_ready = 1'b0;
      if (!hs) check("rand_hs_timeout", 128'(hs), 128'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
